// File: rtl/alu_sll_seq_32bit.sv
// rtl/alu_sll_seq_32bit.sv - sequential logical left shifter, 4-bit then 1-bit steps
module alu_sll_seq_32bit #(
    parameter int N  = 32,
    parameter int SW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [N-1:0]  A,
    input  logic [SW-1:0] SHAMT,
    output logic [N-1:0]  Z,
    output logic          cout,
    output logic          zero,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [SW-1:0] FOUR = SW'(4);
    localparam logic [SW-1:0] ONE  = SW'(1);

    state_t        state;
    state_t        state_next;
    logic [N-1:0]  work;
    logic [SW-1:0] rem;
    logic [N-1:0]  step_work;
    logic [SW-1:0] step_rem;
    logic          step_c;

    // One shift step: coarse 4-bit moves first, then single bits for the remainder.
    always_comb begin
        step_work = work;
        step_rem  = rem;
        step_c    = 1'b0;
        if (rem >= FOUR) begin
            step_work = {work[N-5:0], 4'b0000};
            step_rem  = rem - FOUR;
            step_c    = work[N-4];
        end else if (rem != '0) begin
            step_work = {work[N-2:0], 1'b0};
            step_rem  = rem - ONE;
            step_c    = work[N-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (SHAMT == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (step_rem == '0) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Z and cout only move at completion so they stay stable while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work <= '0;
            rem  <= '0;
            Z    <= '0;
            cout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        work <= A;
                        rem  <= SHAMT;
                        if (SHAMT == '0) begin
                            Z    <= A;
                            cout <= 1'b0;
                        end
                    end
                end
                SHIFT: begin
                    work <= step_work;
                    rem  <= step_rem;
                    if (step_rem == '0) begin
                        Z    <= step_work;
                        cout <= step_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign zero = (Z == '0);

endmodule

// File: tb/tb_alu_sll_seq_32bit.sv
// tb/tb_alu_sll_seq_32bit.sv - directed self-checking bench for alu_sll_seq_32bit
module tb_alu_sll_seq_32bit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] A;
    logic [4:0]  SHAMT;
    logic [31:0] Z;
    logic        cout;
    logic        zero;
    logic        busy;
    logic        done;

    int vectors;
    int miscompares;

    alu_sll_seq_32bit #(.N(32), .SW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .SHAMT (SHAMT),
        .Z     (Z),
        .cout  (cout),
        .zero  (zero),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation from IDLE and check result, latency and the done pulse shape.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [4:0] s,
                          input logic [31:0] exp_z, input logic exp_c, input int exp_m);
        int cyc;
        start = 1'b1;
        A     = a;
        SHAMT = s;
        tick();
        start = 1'b0;
        A     = 32'hDEAD_BEEF;
        SHAMT = 5'd17;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        cyc = 0;
        while (!done && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, "_latency"}, cyc, exp_m);
        check({tag, "_z"}, Z, exp_z);
        check({tag, "_cout"}, {31'd0, cout}, {31'd0, exp_c});
        check({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_z == 32'd0});
        tick();
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int cyc;
        int pulses;
        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0;
        start = 1'b0;
        A     = 32'h0;
        SHAMT = 5'd0;

        #3;
        check("rst_z", Z, 32'h0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        run_op("sh31", 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 10);
        run_op("sh4",  32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFF0, 1'b1, 1);
        run_op("sh0",  32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0, 0);
        run_op("msb1", 32'h8000_0000, 5'd1,  32'h0000_0000, 1'b1, 1);
        run_op("msb2", 32'h8000_0001, 5'd1,  32'h0000_0002, 1'b1, 1);
        run_op("sh7",  32'hA5A5_A5A5, 5'd7,  32'hD2D2_D280, 1'b0, 4);

        // A second start while busy must be ignored; Z holds until completion.
        start = 1'b1;
        A     = 32'h0000_0001;
        SHAMT = 5'd8;
        tick();
        A     = 32'h0000_000F;
        SHAMT = 5'd1;
        check("ign_z_hold", Z, 32'hD2D2_D280);
        cyc = 0;
        while (!done && cyc < 20) begin
            tick();
            cyc++;
        end
        start = 1'b0;
        check("ign_latency", cyc, 2);
        check("ign_z", Z, 32'h0000_0100);
        check("ign_cout", {31'd0, cout}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) pulses++;
            tick();
        end
        check("ign_pulses", pulses, 1);
        check("ign_z_after", Z, 32'h0000_0100);

        // Reset in the middle of a long shift aborts it with no done pulse.
        start = 1'b1;
        A     = 32'h0000_0001;
        SHAMT = 5'd31;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_z", Z, 32'h0);
        check("mid_rst_cout", {31'd0, cout}, 32'd0);
        check("mid_rst_zero", {31'd0, zero}, 32'd1);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        tick();
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            if (done || busy) pulses++;
            tick();
        end
        check("mid_rst_no_done", pulses, 0);
        run_op("post_rst", 32'h0000_0003, 5'd2, 32'h0000_000C, 1'b0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_sll_seq_32bit.md
ALU_SLL_SEQ_32BIT -- requirements
Module: alu_sll_seq_32bit

Interface
REQ-001 SHALL have parameter N, default 32, operand/result width in bits.
REQ-002 SHALL have parameter SW, default 5, shift-amount width; 2^SW = N.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request a shift; sampled only in IDLE.
REQ-006 SHALL have port A  input  N  operand to shift left logically.
REQ-007 SHALL have port SHAMT  input  SW  shift amount, 0..N-1.
REQ-008 SHALL have port Z  output  N  registered result; holds until the next completion.
REQ-009 SHALL have port cout  output  1  last bit shifted out of the MSB end.
REQ-010 SHALL have port zero  output  1  high when Z == 0.
REQ-011 SHALL have port busy  output  1  high in SHIFT and DONE.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE; busy=0 only in IDLE.
REQ-014 SHALL, at edge k with state IDLE and start=1, capture A into a working register and SHAMT into a remaining-count register.
REQ-015 SHALL, at edge k, enter SHIFT if SHAMT != 0; if SHAMT == 0, enter DONE with Z=A and cout=0.
REQ-016 SHALL, on each SHIFT edge with remaining >= 4, shift the working register left by 4, zero-fill, set cout from bit N-4 of the pre-shift value, and decrement remaining by 4.
REQ-017 SHALL, on each SHIFT edge with remaining in 1..3, shift left by 1, zero-fill, set cout from bit N-1 of the pre-shift value, and decrement remaining by 1.
REQ-018 SHALL, on the SHIFT edge where remaining reaches 0, load Z from the shifted value and enter DONE.
REQ-019 SHALL have latency m = floor(s/4) + (s mod 4) SHIFT edges for s = SHAMT; done is high in the cycle after edge k+m (m=0 when s=0); maximum m=10 at s=31.
REQ-020 SHALL assert done for exactly one cycle in DONE, then return to IDLE at the next edge.
REQ-021 SHALL ignore start in SHIFT and DONE; operands captured at edge k are not disturbed by later A/SHAMT changes.
REQ-022 SHALL derive zero combinationally from registered Z only.
REQ-023 SHALL leave Z, cout and zero unchanged between completions, including while busy.
REQ-024 SHALL accept start on the first IDLE cycle after DONE, giving back-to-back throughput of m+2 cycles per operation.

Reset
REQ-025 SHALL, while rst_n=0, immediately force state=IDLE, Z=0, cout=0, zero=1, busy=0, done=0, and clear the working and remaining-count registers.
REQ-026 SHALL, on reset asserted mid-SHIFT or in DONE, abort the operation with no done pulse; first start after rst_n rises is accepted normally.

Verification
REQ-027 SHALL cover: A=0x00000001, SHAMT=31 -> Z=0x80000000, cout=0, zero=0, done 10 edges after start edge.
REQ-028 SHALL cover: A=0xFFFFFFFF, SHAMT=4 -> Z=0xFFFFFFF0, cout=1, done after 1 SHIFT edge.
REQ-029 SHALL cover: A=0x12345678, SHAMT=0 -> Z=0x12345678, cout=0, done in cycle right after start edge, no SHIFT state.
REQ-030 SHALL cover: A=0x80000000, SHAMT=1 -> Z=0x00000000, cout=1, zero=1; then A=0x80000001, SHAMT=1 -> Z=0x00000002, cout=1, zero=0.
REQ-031 SHALL cover: start with A=0x1, SHAMT=8, then start with A=0xF, SHAMT=1 during busy -> second ignored, Z=0x00000100, single done pulse.
REQ-032 SHALL cover: rst_n low for one cycle during SHIFT of SHAMT=31 -> outputs at reset values immediately, no done; next op A=0x3, SHAMT=2 -> Z=0x0000000C.
